// File: rtl/exception_sequencer.sv
// Exception entry / ERET control FSM between CP0 and the pipeline.
// Optional post-redirect holdoff window enabled by defining EXC_SEQ_HOLDOFF_EN.
module exception_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pipe_valid_i,
  input  logic        pendingexception_i,
  input  logic        eret_req_i,
  input  logic [31:0] commit_pc_i,
  input  logic [31:0] epc_i,
  output logic        activeexception_o,
  output logic        eret_o,
  output logic [31:0] exc_pc_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  localparam logic [3:0] DrainLoad = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTake,
    StDrain,
    StRedirect,
    StEret,
    StEretRedir
`ifdef EXC_SEQ_HOLDOFF_EN
    , StHoldoff
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic [31:0] epc_q, epc_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      exc_pc_q <= 32'd0;
      epc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exc_pc_q <= exc_pc_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    exc_pc_d          = exc_pc_q;
    epc_d             = epc_q;
    activeexception_o = 1'b0;
    eret_o            = 1'b0;
    flush_o           = 1'b0;
    stall_o           = 1'b0;
    redirect_o        = 1'b0;
    redirect_pc_o     = 32'd0;

    unique case (state_q)
      StIdle: begin
        // Exception has priority over ERET in the same cycle.
        if (pipe_valid_i && pendingexception_i) begin
          state_d  = StTake;
          exc_pc_d = commit_pc_i;
        end else if (pipe_valid_i && eret_req_i) begin
          state_d = StEret;
        end
      end
      StTake: begin
        activeexception_o = 1'b1;
        flush_o           = 1'b1;
        stall_o           = 1'b1;
        cnt_d             = DrainLoad;
        state_d           = (DrainLoad != 4'd0) ? StDrain : StRedirect;
      end
      StDrain: begin
        flush_o = 1'b1;
        stall_o = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StRedirect;
      end
      StRedirect: begin
        redirect_o    = 1'b1;
        redirect_pc_o = EXC_VECTOR;
`ifdef EXC_SEQ_HOLDOFF_EN
        state_d = StHoldoff;
        cnt_d   = 4'd1;
`else
        state_d = StIdle;
`endif
      end
      StEret: begin
        eret_o  = 1'b1;
        flush_o = 1'b1;
        stall_o = 1'b1;
        epc_d   = epc_i;
        state_d = StEretRedir;
      end
      StEretRedir: begin
        redirect_o    = 1'b1;
        redirect_pc_o = epc_q;
`ifdef EXC_SEQ_HOLDOFF_EN
        state_d = StHoldoff;
        cnt_d   = 4'd1;
`else
        state_d = StIdle;
`endif
      end
`ifdef EXC_SEQ_HOLDOFF_EN
      StHoldoff: begin
        // Two cycles: counter loaded with 1 on entry, exit once it hits 0.
        if (cnt_q == 4'd0) state_d = StIdle;
        else cnt_d = cnt_q - 4'd1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign exc_pc_o = exc_pc_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed scoreboard bench for exception_sequencer: default instance plus a
// FLUSH_CYCLES=1 instance; expected output vectors are queued and compared per cycle.
module tb_exception_sequencer;

  localparam logic [31:0] Vec = 32'h8000_0180;

  typedef logic [69:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        pv, pend, ereq;
  logic [31:0] cpc, epc;
  logic        a_act, a_eret, a_flush, a_stall, a_redir, a_busy;
  logic [31:0] a_xpc, a_rpc;

  logic        b_pv, b_pend, b_ereq;
  logic [31:0] b_cpc, b_epc;
  logic        b_act, b_eret, b_flush, b_stall, b_redir, b_busy;
  logic [31:0] b_xpc, b_rpc;

  exception_sequencer dut (
    .clk_i(clk), .reset_i(reset), .pipe_valid_i(pv), .pendingexception_i(pend),
    .eret_req_i(ereq), .commit_pc_i(cpc), .epc_i(epc), .activeexception_o(a_act),
    .eret_o(a_eret), .exc_pc_o(a_xpc), .flush_o(a_flush), .stall_o(a_stall),
    .redirect_o(a_redir), .redirect_pc_o(a_rpc), .busy_o(a_busy)
  );

  exception_sequencer #(.FLUSH_CYCLES(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .pipe_valid_i(b_pv), .pendingexception_i(b_pend),
    .eret_req_i(b_ereq), .commit_pc_i(b_cpc), .epc_i(b_epc), .activeexception_o(b_act),
    .eret_o(b_eret), .exc_pc_o(b_xpc), .flush_o(b_flush), .stall_o(b_stall),
    .redirect_o(b_redir), .redirect_pc_o(b_rpc), .busy_o(b_busy)
  );

  vec_t obs0, obs1;
  assign obs0 = {a_act, a_eret, a_flush, a_stall, a_redir, a_busy, a_rpc, a_xpc};
  assign obs1 = {b_act, b_eret, b_flush, b_stall, b_redir, b_busy, b_rpc, b_xpc};

  vec_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   sel = 1'b0;

  function automatic vec_t ev(bit a, bit e, bit f, bit s, bit r, bit b,
                              logic [31:0] rpc, logic [31:0] xpc);
    return {a, e, f, s, r, b, rpc, xpc};
  endfunction
  function automatic vec_t e_idle(logic [31:0] x);  return ev(0,0,0,0,0,0,32'd0,x); endfunction
  function automatic vec_t e_take(logic [31:0] x);  return ev(1,0,1,1,0,1,32'd0,x); endfunction
  function automatic vec_t e_drain(logic [31:0] x); return ev(0,0,1,1,0,1,32'd0,x); endfunction
  function automatic vec_t e_redir(logic [31:0] x); return ev(0,0,0,0,1,1,Vec,x);   endfunction
  function automatic vec_t e_eret(logic [31:0] x);  return ev(0,1,1,1,0,1,32'd0,x); endfunction
  function automatic vec_t e_eredir(logic [31:0] x, logic [31:0] p);
    return ev(0,0,0,0,1,1,p,x);
  endfunction
  function automatic vec_t e_hold(logic [31:0] x);  return ev(0,0,0,0,0,1,32'd0,x); endfunction

  task automatic check(input string tag);
    vec_t exp_v, obs_v;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, sel ? obs1 : obs0);
    end else begin
      exp_v = sb.pop_front();
      obs_v = sel ? obs1 : obs0;
      assert (obs_v === exp_v) else begin
        mismatched++;
        $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic step(input vec_t e, input string tag);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check(tag);
  endtask

  // Holdoff cycles that follow any redirect when the option is built in.
  task automatic post_redirect(input logic [31:0] x, input string tag);
`ifdef EXC_SEQ_HOLDOFF_EN
    step(e_hold(x), {tag, "_hold1"});
    step(e_hold(x), {tag, "_hold2"});
`else
    if (tag.len() < 0) step(e_hold(x), tag);
`endif
  endtask

  initial begin
    pv = 0; pend = 0; ereq = 0; cpc = 0; epc = 0;
    b_pv = 0; b_pend = 0; b_ereq = 0; b_cpc = 0; b_epc = 0;

    @(negedge clk);
    sb.push_back(e_idle(32'd0)); check("reset_a");
    sel = 1'b1; sb.push_back(e_idle(32'd0)); check("reset_b"); sel = 1'b0;
    reset = 1'b0;

    // Exception entry; pending held through the drain to show it is ignored.
    pv = 1; pend = 1; cpc = 32'h0040_0010;
    step(e_take(32'h0040_0010), "entry_take");
    cpc = 32'h0000_0bad;
    step(e_drain(32'h0040_0010), "entry_drain1");
    step(e_drain(32'h0040_0010), "entry_drain2");
    step(e_redir(32'h0040_0010), "entry_redirect");
    pv = 0; pend = 0;
    post_redirect(32'h0040_0010, "entry");
    step(e_idle(32'h0040_0010), "entry_idle");

    // ERET: epc changes after capture must not reach redirect_pc.
    pv = 1; ereq = 1; epc = 32'h0040_0014;
    step(e_eret(32'h0040_0010), "eret_pulse");
    pv = 0; ereq = 0;
    step(e_eredir(32'h0040_0010, 32'h0040_0014), "eret_redirect");
    epc = 32'hdead_beef;
    post_redirect(32'h0040_0010, "eret");
    step(e_idle(32'h0040_0010), "eret_idle");

    // Simultaneous requests: exception path only.
    pv = 1; pend = 1; ereq = 1; cpc = 32'h0040_0100;
    step(e_take(32'h0040_0100), "simul_take");
    pv = 0; pend = 0; ereq = 0;
    step(e_drain(32'h0040_0100), "simul_drain1");
    step(e_drain(32'h0040_0100), "simul_drain2");
    step(e_redir(32'h0040_0100), "simul_redirect");
    post_redirect(32'h0040_0100, "simul");
    step(e_idle(32'h0040_0100), "simul_idle");

    // pipe_valid low blocks acceptance.
    pend = 1; cpc = 32'h0040_0200;
    for (int i = 0; i < 5; i++) step(e_idle(32'h0040_0100), "novalid_idle");
    pv = 1;
    step(e_take(32'h0040_0200), "novalid_take");
    step(e_drain(32'h0040_0200), "rst_pre_drain");

    // Asynchronous reset in the middle of the drain.
    #1 reset = 1'b1;
    #1 sb.push_back(e_idle(32'd0)); check("rst_async");
    step(e_idle(32'd0), "rst_held");
    reset = 1'b0;
    step(e_take(32'h0040_0200), "rst_retake");
    pv = 0; pend = 0;
    step(e_drain(32'h0040_0200), "rst_drain1");
    step(e_drain(32'h0040_0200), "rst_drain2");
    step(e_redir(32'h0040_0200), "rst_redirect");
    post_redirect(32'h0040_0200, "rst");
    step(e_idle(32'h0040_0200), "rst_idle");

    // FLUSH_CYCLES=1 instance: TAKE then REDIRECT directly.
    sel = 1'b1;
    b_pv = 1; b_pend = 1; b_cpc = 32'h0040_0300;
    step(e_take(32'h0040_0300), "f1_take");
    step(e_redir(32'h0040_0300), "f1_redirect");
`ifdef EXC_SEQ_HOLDOFF_EN
    step(e_hold(32'h0040_0300), "f1_hold1");
    step(e_hold(32'h0040_0300), "f1_hold2");
`endif
    b_pv = 0; b_pend = 0;
    step(e_idle(32'h0040_0300), "f1_idle1");
    step(e_idle(32'h0040_0300), "f1_idle2");
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
